stream_pattern_gen: RTL and testbench

- AXI4-Stream source that produces deterministic test patterns: counter, PRBS31, fixed, or alternating.
- Its output feeds the stream comparator's inputs for link and loopback testing; two instances with equal settings give bit-identical streams.
- Runs continuously or for a programmed burst, with backpressure-safe handshaking and optional single-word error injection.

---
 rtl/stream_pattern_gen_pkg.sv | 29 ++
 rtl/stream_pattern_gen_prbs31.sv | 34 +++
 rtl/stream_pattern_gen.sv | 174 +++++++++++++++++
 tb/tb_stream_pattern_gen.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pattern_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_pattern_gen_pkg
// Description : Shared types and PRBS31 constants for the stream pattern
//               generator and its parallel LFSR helper.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT  = 2'd0,
    MODE_PRBS31 = 2'd1,
    MODE_FIXED  = 2'd2,
    MODE_ALT    = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // x^31 + x^28 + 1
  localparam int                  PRBS_LEN          = 31;
  localparam int                  PRBS_TAP          = 28;
  localparam logic [PRBS_LEN-1:0] PRBS_DEFAULT_SEED = '1;

endpackage : stream_pattern_gen_pkg
`default_nettype wire

// File: rtl/stream_pattern_gen_prbs31.sv
`default_nettype none
// ============================================================================
// Module      : prbs31_parallel
// Description : Combinational PRBS31 (x^31+x^28+1, Fibonacci) unrolled by
//               TDATA_WIDTH steps. Earliest output bit lands in the MSB.
// Revision    : 1.0 - initial release
// ============================================================================
module prbs31_parallel
  import stream_pattern_gen_pkg::*;
#(
  parameter int TDATA_WIDTH = 32
) (
  input  logic [PRBS_LEN-1:0]    i_state,
  output logic [PRBS_LEN-1:0]    o_next,
  output logic [TDATA_WIDTH-1:0] o_bits
);

  // Step the LFSR once per output bit; the feedback bit is the emitted bit.
  always_comb begin
    logic [PRBS_LEN-1:0] w_shift;
    logic                w_fb;
    w_shift = i_state;
    w_fb    = 1'b0;
    o_bits  = '0;
    for (int i = 0; i < TDATA_WIDTH; i++) begin
      w_fb                     = w_shift[PRBS_LEN-1] ^ w_shift[PRBS_TAP-1];
      o_bits[TDATA_WIDTH-1-i]  = w_fb;
      w_shift                  = {w_shift[PRBS_LEN-2:0], w_fb};
    end
    o_next = w_shift;
  end

endmodule : prbs31_parallel
`default_nettype wire

// File: rtl/stream_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : stream_pattern_gen
// Description : AXI4-Stream deterministic pattern source (counter, PRBS31,
//               fixed, alternating) with burst/continuous runs.
//               Optional single-word bit-0 error injection is built when
//               STREAM_PATTERN_GEN_ERR_INJECT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_pattern_gen
  import stream_pattern_gen_pkg::*;
#(
  parameter int TDATA_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic [1:0]             mode,
  input  logic [TDATA_WIDTH-1:0] seed,
  input  logic [31:0]            burst_len,
  input  logic                   inject_err,
  output logic [TDATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                   M_AXIS_TVALID,
  input  logic                   M_AXIS_TREADY,
  output logic                   M_AXIS_TLAST,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            word_count
);

  state_t                 r_state;
  state_t                 w_state_next;
  mode_t                  r_mode;
  logic [31:0]            r_burst;
  logic [31:0]            r_pos;        // 1-based index of the presented word
  logic [31:0]            r_count;
  logic [TDATA_WIDTH-1:0] r_data;       // clean generator word
  logic [PRBS_LEN-1:0]    r_lfsr;       // LFSR state after the presented word
  logic                   r_done;

  logic                   w_valid;
  logic                   w_accept;
  logic                   w_last;
  logic                   w_start;
  logic                   w_flip;
  logic [PRBS_LEN-1:0]    w_seed_raw;
  logic [PRBS_LEN-1:0]    w_seed31;
  logic [PRBS_LEN-1:0]    w_prbs_in;
  logic [PRBS_LEN-1:0]    w_prbs_next;
  logic [TDATA_WIDTH-1:0] w_prbs_bits;
  logic [TDATA_WIDTH-1:0] w_first;
  logic [TDATA_WIDTH-1:0] w_gen_next;

  assign w_valid  = (r_state != IDLE);
  assign w_accept = w_valid && M_AXIS_TREADY;
  assign w_last   = (r_burst != 32'd0) && (r_pos == r_burst);
  assign w_start  = (r_state == IDLE) && start && !stop;

  // Narrow data widths zero-extend the seed into the 31-bit LFSR.
  generate
    if (TDATA_WIDTH >= PRBS_LEN) begin : g_seed_wide
      assign w_seed_raw = seed[PRBS_LEN-1:0];
    end else begin : g_seed_narrow
      assign w_seed_raw = PRBS_LEN'(seed);
    end
  endgenerate

  assign w_seed31  = (w_seed_raw == '0) ? PRBS_DEFAULT_SEED : w_seed_raw;
  // In IDLE the unroller produces the first word straight from the seed.
  assign w_prbs_in = (r_state == IDLE) ? w_seed31 : r_lfsr;

  prbs31_parallel #(
    .TDATA_WIDTH (TDATA_WIDTH)
  ) u_prbs (
    .i_state (w_prbs_in),
    .o_next  (w_prbs_next),
    .o_bits  (w_prbs_bits)
  );

  // First word of a run and the word following an accept.
  always_comb begin
    w_first    = seed;
    w_gen_next = r_data;
    if (mode_t'(mode) == MODE_PRBS31) begin
      w_first = w_prbs_bits;
    end
    case (r_mode)
      MODE_COUNT:  w_gen_next = r_data + 1'b1;
      MODE_PRBS31: w_gen_next = w_prbs_bits;
      MODE_FIXED:  w_gen_next = r_data;
      MODE_ALT:    w_gen_next = ~r_data;
      default:     w_gen_next = r_data;
    endcase
  end

  // Next-state decode; stop wins over start and an accepted stop word ends the run.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_start) w_state_next = RUN;
      end
      RUN: begin
        if (w_accept && w_last) w_state_next = IDLE;
        else if (stop)          w_state_next = w_accept ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (w_accept) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register, run configuration and generator advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_mode  <= MODE_COUNT;
      r_burst <= '0;
      r_pos   <= '0;
      r_count <= '0;
      r_data  <= '0;
      r_lfsr  <= PRBS_DEFAULT_SEED;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_accept && w_last;
      if (w_start) begin
        r_mode  <= mode_t'(mode);
        r_burst <= burst_len;
        r_pos   <= 32'd1;
        r_count <= '0;
        r_data  <= w_first;
        r_lfsr  <= w_prbs_next;
      end else if (w_accept) begin
        r_pos   <= r_pos + 32'd1;
        r_count <= r_count + 32'd1;
        r_data  <= w_gen_next;
        r_lfsr  <= w_prbs_next;
      end
    end
  end

`ifdef STREAM_PATTERN_GEN_ERR_INJECT_EN
  logic r_err_pend;

  // Pending flag corrupts whichever word is presented until it is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_pend <= 1'b0;
    end else if (r_state == IDLE) begin
      r_err_pend <= 1'b0;
    end else begin
      r_err_pend <= (r_err_pend && !w_accept) || inject_err;
    end
  end

  assign w_flip = r_err_pend && w_valid;
`else
  logic w_unused_inject;
  assign w_unused_inject = inject_err;
  assign w_flip          = 1'b0;
`endif

  assign M_AXIS_TDATA  = {r_data[TDATA_WIDTH-1:1], r_data[0] ^ w_flip};
  assign M_AXIS_TVALID = w_valid;
  assign M_AXIS_TLAST  = w_valid && w_last;
  assign busy          = w_valid;
  assign done          = r_done;
  assign word_count    = r_count;

endmodule : stream_pattern_gen
`default_nettype wire

// File: tb/tb_stream_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_pattern_gen
// Description : Scoreboard bench for stream_pattern_gen (TDATA_WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_pattern_gen;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [W-1:0]  seed = '0;
  logic [31:0]   burst_len = '0;
  logic          inject_err = 1'b0;
  logic [W-1:0]  tdata;
  logic          tvalid;
  logic          tready = 1'b0;
  logic          tlast;
  logic          busy;
  logic          done;
  logic [31:0]   word_count;

  stream_pattern_gen #(.TDATA_WIDTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stop          (stop),
    .mode          (mode),
    .seed          (seed),
    .burst_len     (burst_len),
    .inject_err    (inject_err),
    .M_AXIS_TDATA  (tdata),
    .M_AXIS_TVALID (tvalid),
    .M_AXIS_TREADY (tready),
    .M_AXIS_TLAST  (tlast),
    .busy          (busy),
    .done          (done),
    .word_count    (word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          done_seen = 0;
  logic [30:0] m_lfsr;
  logic        hold_pending = 1'b0;
  logic [W-1:0] hold_data = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  // Reference PRBS31: feedback bit s[30]^s[27] is emitted, MSB first.
  function automatic logic [W-1:0] prbs_word();
    logic [W-1:0] w;
    logic         fb;
    w = '0;
    for (int b = W - 1; b >= 0; b--) begin
      fb     = m_lfsr[30] ^ m_lfsr[27];
      w[b]   = fb;
      m_lfsr = {m_lfsr[29:0], fb};
    end
    return w;
  endfunction

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      tick();
      n++;
    end
    chk("idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Accept monitor: pop the scoreboard on each handshake, check stall stability.
  always @(negedge clk) begin
    if (!reset) begin
      if (done) done_seen++;
      if (hold_pending && tvalid) chk("hold_data", 64'(tdata), 64'(hold_data));
      hold_pending = tvalid && !tready;
      hold_data    = tdata;
      if (tvalid && tready) begin
        chk("sb_nonempty", {63'd0, exp_q.size() != 0}, 64'd1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("tdata", 64'(tdata), 64'(e.data));
          chk("tlast", {63'd0, tlast}, {63'd0, e.last});
        end
      end
    end else begin
      hold_pending = 1'b0;
    end
  end

  initial begin
    int d0;
    int guard;
    logic [W-1:0] w;

    // Reset state
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_tvalid", {63'd0, tvalid}, 64'd0);
    chk("rst_tdata", 64'(tdata), 64'd0);
    chk("rst_tlast", {63'd0, tlast}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_count", 64'(word_count), 64'd0);

    // Counter burst, full throughput
    mode = 2'd0; seed = 32'd5; burst_len = 32'd4; tready = 1'b1;
    push(32'd5, 1'b0); push(32'd6, 1'b0); push(32'd7, 1'b0); push(32'd8, 1'b1);
    d0 = done_seen;
    pulse_start();
    wait_idle(100);
    tick();
    chk("t1_count", 64'(word_count), 64'd4);
    chk("t1_done", 64'(done_seen - d0), 64'd1);
    chk("t1_sb_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure while word 6 is presented
    tready = 1'b0;
    push(32'd5, 1'b0); push(32'd6, 1'b0); push(32'd7, 1'b0); push(32'd8, 1'b1);
    d0 = done_seen;
    pulse_start();
    tready = 1'b1;
    tick();
    tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_stall_data", 64'(tdata), 64'd6);
      chk("t2_stall_valid", {63'd0, tvalid}, 64'd1);
      chk("t2_stall_count", 64'(word_count), 64'd1);
    end
    tready = 1'b1;
    wait_idle(100);
    tick();
    chk("t2_count", 64'(word_count), 64'd4);
    chk("t2_done", 64'(done_seen - d0), 64'd1);

    // PRBS31 continuous, zero seed, random backpressure, stopped during a stall
    mode = 2'd1; seed = '0; burst_len = 32'd0;
    m_lfsr = 31'h7FFF_FFFF;
    for (int i = 0; i < 2001; i++) push(prbs_word(), 1'b0);
    d0 = done_seen;
    pulse_start();
    guard = 0;
    while (word_count != 32'd2000 && guard < 40000) begin
      tready = 1'($urandom_range(0, 1));
      tick();
      guard++;
    end
    chk("t3_reach_count", 64'(word_count), 64'd2000);
    tready = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tready = 1'b1;
    wait_idle(100);
    tick();
    chk("t3_count", 64'(word_count), 64'd2001);
    chk("t3_no_done", 64'(done_seen - d0), 64'd0);
    chk("t3_sb_empty", 64'(exp_q.size()), 64'd0);

    // Stop during a stall in continuous counter mode, then restart from seed
    mode = 2'd0; seed = 32'd100; burst_len = 32'd0; tready = 1'b1;
    push(32'd100, 1'b0); push(32'd101, 1'b0); push(32'd102, 1'b0);
    d0 = done_seen;
    pulse_start();
    tick(); tick();
    tready = 1'b0;
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick(); tick();
    chk("t4_drain_valid", {63'd0, tvalid}, 64'd1);
    chk("t4_drain_data", 64'(tdata), 64'd102);
    tready = 1'b1;
    wait_idle(100);
    tick();
    chk("t4_tvalid_low", {63'd0, tvalid}, 64'd0);
    chk("t4_count", 64'(word_count), 64'd3);
    chk("t4_no_done", 64'(done_seen - d0), 64'd0);
    burst_len = 32'd2;
    push(32'd100, 1'b0); push(32'd101, 1'b1);
    pulse_start();
    wait_idle(100);
    tick();
    chk("t4_restart_count", 64'(word_count), 64'd2);

    // Fixed pattern with an injection aimed at word 3
    mode = 2'd2; seed = 32'hA5A5_A5A5; burst_len = 32'd6; tready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      w = 32'hA5A5_A5A5;
`ifdef STREAM_PATTERN_GEN_ERR_INJECT_EN
      if (i == 3) w = 32'hA5A5_A5A4;
`endif
      push(w, i == 6);
    end
    d0 = done_seen;
    pulse_start();
    tick();
    inject_err = 1'b1;
    tick();
    inject_err = 1'b0;
    wait_idle(100);
    tick();
    chk("t5_count", 64'(word_count), 64'd6);
    chk("t5_done", 64'(done_seen - d0), 64'd1);

    // Alternating pattern, burst of one
    mode = 2'd3; seed = 32'h0F0F_1234; burst_len = 32'd1;
    push(32'h0F0F_1234, 1'b1);
    pulse_start();
    wait_idle(100);
    tick();
    chk("t6_count", 64'(word_count), 64'd1);
    burst_len = 32'd3;
    push(32'h0F0F_1234, 1'b0); push(32'hF0F0_EDCB, 1'b0); push(32'h0F0F_1234, 1'b1);
    pulse_start();
    wait_idle(100);
    tick();

    // Reset mid-burst, then start+stop together from IDLE
    mode = 2'd0; seed = 32'd0; burst_len = 32'd10; tready = 1'b1;
    for (int i = 0; i < 10; i++) push(32'(i), i == 9);
    d0 = done_seen;
    pulse_start();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    chk("t7_tvalid", {63'd0, tvalid}, 64'd0);
    chk("t7_count", 64'(word_count), 64'd0);
    chk("t7_busy", {63'd0, busy}, 64'd0);
    tick();
    chk("t7_no_done", 64'(done_seen - d0), 64'd0);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    tick();
    chk("t7_startstop_busy", {63'd0, busy}, 64'd0);
    chk("t7_startstop_valid", {63'd0, tvalid}, 64'd0);
    chk("t7_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_stream_pattern_gen
`default_nettype wire
